// File: rtl/miyamii_pkg.sv
// Shared definitions for the fetch bus: phase encoding, bus and ROM widths,
// and the responder's FSM state type.
package miyamii_pkg;

    localparam int NIBBLE_W = 4;
    localparam int ROM_AW   = 8;
    localparam int PHASE_W  = 3;

    localparam logic [PHASE_W-1:0] PH_A1   = 3'd0;
    localparam logic [PHASE_W-1:0] PH_A2   = 3'd1;
    localparam logic [PHASE_W-1:0] PH_A3   = 3'd2;
    localparam logic [PHASE_W-1:0] PH_M1   = 3'd3;
    localparam logic [PHASE_W-1:0] PH_M2   = 3'd4;
    localparam logic [PHASE_W-1:0] PH_X1   = 3'd5;
    localparam logic [PHASE_W-1:0] PH_X2   = 3'd6;
    localparam logic [PHASE_W-1:0] PH_X3   = 3'd7;
    localparam logic [PHASE_W-1:0] PH_IDLE = 3'd0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_A1,
        ST_A2,
        ST_A3,
        ST_M1,
        ST_M2,
        ST_X1,
        ST_X2,
        ST_X3
    } busState_t;

    // Idle shares code 0 with A1 on the phase output.
    function automatic logic [PHASE_W-1:0] phaseOf(input busState_t s);
        logic [PHASE_W-1:0] ph;
        ph = PH_IDLE;
        case (s)
            ST_A1:   ph = PH_A1;
            ST_A2:   ph = PH_A2;
            ST_A3:   ph = PH_A3;
            ST_M1:   ph = PH_M1;
            ST_M2:   ph = PH_M2;
            ST_X1:   ph = PH_X1;
            ST_X2:   ph = PH_X2;
            ST_X3:   ph = PH_X3;
            default: ph = PH_IDLE;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/rom_bus_responder.sv
// Program-memory slice on the multiplexed 4-bit fetch bus: collects the PC nibbles,
// reads the external ROM when A3 selects this slice, and returns OPR/OPA in M1/M2.
module rom_bus_responder
    import miyamii_pkg::*;
#(
    parameter logic [NIBBLE_W-1:0] CHIP_ID = 4'h0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sync_i,
    input  logic [NIBBLE_W-1:0] d_i,
    output logic [NIBBLE_W-1:0] d_o,
    output logic                d_oe,
    output logic [ROM_AW-1:0]   mem_addr,
    output logic                mem_rd_en,
    input  logic [7:0]          mem_rdata,
    output logic [7:0]          instr_o,
    output logic                instr_valid,
    output logic                selected_o,
    output logic                sync_err,
    output logic [PHASE_W-1:0]  phase_o
);

    busState_t          r_state;
    logic [ROM_AW-1:0]  r_memAddr;
    logic [7:0]         r_opcode;
    logic [7:0]         r_instr;
    logic               r_instrValid;
    logic               r_selected;
    logic               r_syncErr;

    logic               w_chipHit;
    logic               w_abort;
    logic               w_busPhase;

    assign w_chipHit  = (d_i == CHIP_ID);
    assign w_busPhase = (r_state == ST_M1) || (r_state == ST_M2);
    // A marker anywhere before X3 means the initiator restarted mid-cycle.
    assign w_abort    = sync_i && (r_state != ST_IDLE) && (r_state != ST_X3);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_memAddr    <= '0;
            r_opcode     <= '0;
            r_instr      <= '0;
            r_instrValid <= 1'b0;
            r_selected   <= 1'b0;
            r_syncErr    <= 1'b0;
        end else begin
            r_instrValid <= 1'b0;
            r_syncErr    <= 1'b0;
            if (w_abort) begin
                r_state    <= ST_A1;
                r_syncErr  <= 1'b1;
                r_selected <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (sync_i) r_state <= ST_A1;
                    end
                    ST_A1: begin
                        r_memAddr[3:0] <= d_i;
                        r_state        <= ST_A2;
                    end
                    ST_A2: begin
                        r_memAddr[7:4] <= d_i;
                        r_state        <= ST_A3;
                    end
                    ST_A3: begin
                        r_selected <= w_chipHit;
                        r_state    <= ST_M1;
                    end
                    ST_M1: begin
                        r_opcode <= mem_rdata;
                        r_state  <= ST_M2;
                    end
                    ST_M2: begin
                        r_state <= ST_X1;
                    end
                    ST_X1: begin
                        if (r_selected) begin
                            r_instr      <= r_opcode;
                            r_instrValid <= 1'b1;
                        end
                        r_state <= ST_X2;
                    end
                    ST_X2: begin
                        r_state <= ST_X3;
                    end
                    ST_X3: begin
                        r_selected <= 1'b0;
                        r_state    <= sync_i ? ST_A1 : ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Bus drive and ROM strobe are gated by rst directly so a mid-cycle reset
    // releases the bus before the next edge.
    assign mem_rd_en = !rst && (r_state == ST_A3) && w_chipHit;
    assign d_oe      = !rst && r_selected && w_busPhase;
    assign d_o       = !d_oe ? '0 :
                       (r_state == ST_M1) ? mem_rdata[7:4] : r_opcode[3:0];

    assign mem_addr    = r_memAddr;
    assign instr_o     = r_instr;
    assign instr_valid = r_instrValid;
    assign selected_o  = r_selected;
    assign sync_err    = r_syncErr;
    assign phase_o     = phaseOf(r_state);

endmodule

// File: tb/tb_rom_bus_responder.sv
// Self-checking bench: table of fetches, random back-to-back fetches against a
// fetch-level model, plus abort, idle and mid-cycle reset sequences.
module tb_rom_bus_responder;
    import miyamii_pkg::*;

    localparam logic [3:0] CHIP_ID = 4'h0;

    logic       clk = 1'b0;
    logic       rst;
    logic       sync_i;
    logic [3:0] d_i;
    logic [3:0] d_o;
    logic       d_oe;
    logic [7:0] mem_addr;
    logic       mem_rd_en;
    logic [7:0] mem_rdata;
    logic [7:0] instr_o;
    logic       instr_valid;
    logic       selected_o;
    logic       sync_err;
    logic [2:0] phase_o;

    logic [7:0] rom [256];
    logic [7:0] expInstr;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        logic [11:0] pc;
        logic [7:0]  romVal;
        logic        expSel;
        logic        syncAtEnd;
    } fetchVec_t;

    fetchVec_t vecs [6];

    rom_bus_responder #(.CHIP_ID(CHIP_ID)) dut (
        .clk         (clk),
        .rst         (rst),
        .sync_i      (sync_i),
        .d_i         (d_i),
        .d_o         (d_o),
        .d_oe        (d_oe),
        .mem_addr    (mem_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_rdata   (mem_rdata),
        .instr_o     (instr_o),
        .instr_valid (instr_valid),
        .selected_o  (selected_o),
        .sync_err    (sync_err),
        .phase_o     (phase_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= rom[mem_addr];
    end

    task automatic checkOutput(input string name, input logic [11:0] actual, input logic [11:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Inputs change on the falling edge; combinational outputs are sampled 1ns later.
    task automatic applyStimulus(input logic rstV, input logic syncV, input logic [3:0] dV);
        @(negedge clk);
        rst    = rstV;
        sync_i = syncV;
        d_i    = dV;
        #1;
    endtask

    // One bus cycle starting in A1; stops early after the abort phase (sync or reset).
    task automatic runFetch(input logic [11:0] pc, input logic syncAtEnd,
                            input int abortPhase, input logic abortIsReset);
        logic       sel;
        logic [7:0] byteV;
        logic [3:0] dV;
        logic       syncV;
        logic       rstV;
        logic       expRd;
        logic       expOe;
        logic [3:0] expDo;
        sel   = (pc[11:8] == CHIP_ID);
        byteV = rom[pc[7:0]];
        for (int ph = 0; ph < 8; ph++) begin
            dV    = (ph == 0) ? pc[3:0] : (ph == 1) ? pc[7:4] : (ph == 2) ? pc[11:8] : 4'h0;
            syncV = ((ph == 7) && syncAtEnd) || ((ph == abortPhase) && !abortIsReset);
            rstV  = (ph == abortPhase) && abortIsReset;
            applyStimulus(rstV, syncV, dV);
            expRd = !rstV && (ph == 2) && sel;
            expOe = !rstV && sel && ((ph == 3) || (ph == 4));
            expDo = !expOe ? 4'h0 : (ph == 3) ? byteV[7:4] : byteV[3:0];
            if ((ph == 6) && sel) expInstr = byteV;
            checkOutput($sformatf("phase_o pc=%03h ph%0d", pc, ph), 12'(phase_o), 12'(ph));
            checkOutput($sformatf("mem_rd_en pc=%03h ph%0d", pc, ph), 12'(mem_rd_en), 12'(expRd));
            checkOutput($sformatf("d_oe pc=%03h ph%0d", pc, ph), 12'(d_oe), 12'(expOe));
            checkOutput($sformatf("d_o pc=%03h ph%0d", pc, ph), 12'(d_o), 12'(expDo));
            checkOutput($sformatf("instr_valid pc=%03h ph%0d", pc, ph), 12'(instr_valid),
                        12'((ph == 6) && sel));
            checkOutput($sformatf("instr_o pc=%03h ph%0d", pc, ph), 12'(instr_o), 12'(expInstr));
            if (ph == 2)
                checkOutput($sformatf("mem_addr pc=%03h", pc), 12'(mem_addr), 12'(pc[7:0]));
            if (ph >= 3)
                checkOutput($sformatf("selected_o pc=%03h ph%0d", pc, ph), 12'(selected_o), 12'(sel));
            if (ph >= 1)
                checkOutput($sformatf("sync_err pc=%03h ph%0d", pc, ph), 12'(sync_err), 12'h0);
            if (ph == abortPhase) return;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0]  tablePrev;
        logic [11:0] rpc;

        vecs[0] = '{pc: 12'h05A, romVal: 8'hD3, expSel: 1'b1, syncAtEnd: 1'b1};
        vecs[1] = '{pc: 12'h15A, romVal: 8'h3C, expSel: 1'b0, syncAtEnd: 1'b1};
        vecs[2] = '{pc: 12'h000, romVal: 8'h12, expSel: 1'b1, syncAtEnd: 1'b1};
        vecs[3] = '{pc: 12'h001, romVal: 8'h34, expSel: 1'b1, syncAtEnd: 1'b1};
        vecs[4] = '{pc: 12'h002, romVal: 8'h56, expSel: 1'b1, syncAtEnd: 1'b1};
        vecs[5] = '{pc: 12'h003, romVal: 8'h78, expSel: 1'b1, syncAtEnd: 1'b0};

        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        expInstr  = 8'h00;
        tablePrev = 8'h00;

        // Reset state
        rst = 1'b1; sync_i = 1'b0; d_i = 4'h0;
        applyStimulus(1'b1, 1'b0, 4'h0);
        applyStimulus(1'b1, 1'b0, 4'h0);
        checkOutput("reset phase_o", 12'(phase_o), 12'h0);
        checkOutput("reset instr_o", 12'(instr_o), 12'h0);
        checkOutput("reset mem_addr", 12'(mem_addr), 12'h0);
        checkOutput("reset selected_o", 12'(selected_o), 12'h0);
        checkOutput("reset instr_valid", 12'(instr_valid), 12'h0);
        checkOutput("reset sync_err", 12'(sync_err), 12'h0);
        checkOutput("reset d_oe", 12'(d_oe), 12'h0);
        checkOutput("reset mem_rd_en", 12'(mem_rd_en), 12'h0);

        applyStimulus(1'b0, 1'b0, 4'h0);
        applyStimulus(1'b0, 1'b1, 4'h0);

        // Table fetches: selected, unselected (instr held), then four back-to-back
        for (int i = 0; i < 6; i++) begin
            rom[vecs[i].pc[7:0]] = vecs[i].romVal;
            runFetch(vecs[i].pc, vecs[i].syncAtEnd, 8, 1'b0);
            if (vecs[i].expSel) tablePrev = vecs[i].romVal;
            checkOutput($sformatf("table instr_o vec%0d", i), 12'(instr_o), 12'(tablePrev));
        end

        // No sync in X3: bus stays idle even with a matching chip id on d_i
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, CHIP_ID);
            checkOutput($sformatf("idle phase_o %0d", i), 12'(phase_o), 12'h0);
            checkOutput($sformatf("idle mem_rd_en %0d", i), 12'(mem_rd_en), 12'h0);
            checkOutput($sformatf("idle d_oe %0d", i), 12'(d_oe), 12'h0);
        end
        applyStimulus(1'b0, 1'b1, 4'h0);
        runFetch(12'h010, 1'b1, 8, 1'b0);

        // Sync in M2 aborts the cycle
        runFetch(12'h020, 1'b0, 4, 1'b0);
        @(posedge clk); #1;
        checkOutput("abort phase_o", 12'(phase_o), 12'h0);
        checkOutput("abort sync_err", 12'(sync_err), 12'h1);
        checkOutput("abort instr_valid", 12'(instr_valid), 12'h0);
        checkOutput("abort selected_o", 12'(selected_o), 12'h0);
        checkOutput("abort instr_o", 12'(instr_o), 12'(expInstr));
        runFetch(12'h021, 1'b1, 8, 1'b0);

        // Random back-to-back fetches across three slices
        for (int i = 0; i < 20; i++) begin
            rpc = {4'($urandom_range(0, 2)), 8'($urandom)};
            runFetch(rpc, 1'b1, 8, 1'b0);
        end

        // Reset asserted during M1 of a selected fetch
        rom[8'hAB] = 8'hE7;
        runFetch(12'h0AB, 1'b0, 3, 1'b1);
        @(posedge clk); #1;
        expInstr = 8'h00;
        checkOutput("midreset phase_o", 12'(phase_o), 12'h0);
        checkOutput("midreset selected_o", 12'(selected_o), 12'h0);
        checkOutput("midreset instr_o", 12'(instr_o), 12'h0);
        checkOutput("midreset d_oe", 12'(d_oe), 12'h0);
        checkOutput("midreset mem_addr", 12'(mem_addr), 12'h0);
        applyStimulus(1'b0, 1'b0, 4'h0);
        checkOutput("post-reset phase_o", 12'(phase_o), 12'h0);
        applyStimulus(1'b0, 1'b1, 4'h0);
        runFetch(12'h0AB, 1'b0, 8, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
